// File: rtl/load_store_unit_pkg.sv
// Shared types and helpers for the load/store unit.
//   - load/store funct3 encodings (RISC-V LOAD/STORE major opcodes)
//   - FSM state encoding for the transaction sequencer
//   - fault-cause encoding reported on o_faultCause
//   - legality and alignment helpers evaluated on the incoming request
package load_store_unit_pkg;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } load_funct3_e;

    typedef enum logic [2:0] {
        SB = 3'b000,
        SH = 3'b001,
        SW = 3'b010
    } store_funct3_e;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_REQ       = 2'b01,
        ST_WAIT_RESP = 2'b10,
        ST_DONE      = 2'b11
    } lsu_state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE       = 2'b00,
        CAUSE_MISALIGNED = 2'b01,
        CAUSE_TIMEOUT    = 2'b10,
        CAUSE_ILLEGAL    = 2'b11
    } fault_cause_e;

    // True when funct3 names a width/sign the given direction supports.
    function automatic logic funct3_legal(input logic is_store, input logic [2:0] funct3);
        logic legal;
        if (is_store) begin
            legal = (funct3 == SB) || (funct3 == SH) || (funct3 == SW);
        end else begin
            legal = (funct3 == LB) || (funct3 == LH) || (funct3 == LW) ||
                    (funct3 == LBU) || (funct3 == LHU);
        end
        return legal;
    endfunction

    // Halfwords need an even address, words a multiple of four.
    // Only meaningful for legal funct3 values.
    function automatic logic addr_misaligned(input logic [2:0] funct3, input logic [1:0] offset);
        logic mis;
        case (funct3[1:0])
            2'b01:   mis = offset[0];
            2'b10:   mis = (offset != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Purely combinational byte-lane steering for the load/store unit.
//   Store side: st_size (funct3[1:0]), st_offset (addr[1:0]), st_data (rs2)
//               -> st_lane_data (replicated across lanes), st_byte_en.
//   Load side:  ld_funct3, ld_offset, ld_word (bus read word)
//               -> ld_result (shifted down and sign/zero-extended).
module lsu_lane_align
    import load_store_unit_pkg::*;
(
    input  logic [1:0]  st_size,
    input  logic [1:0]  st_offset,
    input  logic [31:0] st_data,
    output logic [31:0] st_lane_data,
    output logic [3:0]  st_byte_en,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_offset,
    input  logic [31:0] ld_word,
    output logic [31:0] ld_result
);

    // Each lane picks its byte from the replicated pattern, so the memory
    // side can simply write whichever lanes are enabled.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);

            assign st_lane_data[8*gi +: 8] =
                (st_size == 2'b00) ? st_data[7:0] :
                (st_size == 2'b01) ? st_data[8*(gi%2) +: 8] :
                (st_size == 2'b10) ? st_data[8*gi +: 8] :
                                     8'h00;

            assign st_byte_en[gi] =
                (st_size == 2'b00) ? (st_offset == LANE) :
                (st_size == 2'b01) ? (st_offset[1] == LANE[1]) :
                                     (st_size == 2'b10);
        end
    endgenerate

    logic [31:0] ld_shifted;
    assign ld_shifted = ld_word >> {ld_offset, 3'b000};

    always_comb begin
        ld_result = 32'h0;
        case (ld_funct3)
            LB:      ld_result = {{24{ld_shifted[7]}}, ld_shifted[7:0]};
            LH:      ld_result = {{16{ld_shifted[15]}}, ld_shifted[15:0]};
            // Words are always aligned by the time a response arrives,
            // so the shift is zero here.
            LW:      ld_result = ld_shifted;
            LBU:     ld_result = {24'h0, ld_shifted[7:0]};
            LHU:     ld_result = {16'h0, ld_shifted[15:0]};
            default: ld_result = 32'h0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory access stage after the ALU. Converts a load/store request into
// a valid/ready bus transaction, stalls the core until completion, and
// returns extended load data or a fault indication.
//   i_clk, i_rst_n          clock, synchronous active-low reset
//   i_memRequest/i_memWrite  request and direction from the core
//   i_funct3, i_address      width/sign and effective address
//   i_writeData              store data (rs2)
//   o_stall                  hold PC/writeback
//   o_readData               extended load result (updated entering DONE)
//   o_fault, o_faultCause    one-cycle fault report in DONE
//   o_bus*/i_bus*            data bus request and read response
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_memRequest,
    input  logic        i_memWrite,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_address,
    input  logic [31:0] i_writeData,
    output logic        o_stall,
    output logic [31:0] o_readData,
    output logic        o_fault,
    output logic [1:0]  o_faultCause,
    output logic        o_busValid,
    input  logic        i_busReady,
    output logic        o_busWrite,
    output logic [31:0] o_busAddress,
    output logic [31:0] o_busWriteData,
    output logic [3:0]  o_busByteEnable,
    input  logic        i_busReadValid,
    input  logic [31:0] i_busReadData
);

    localparam logic [1:0] IDLE      = ST_IDLE;
    localparam logic [1:0] REQ       = ST_REQ;
    localparam logic [1:0] WAIT_RESP = ST_WAIT_RESP;
    localparam logic [1:0] DONE      = ST_DONE;

    // The counter only needs to reach TIMEOUT_CYCLES-1: the cycle on which
    // it holds that value is the last one spent waiting.
    localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]       state_reg, state_next;
    logic [CNT_W-1:0] count_reg;
    logic [1:0]       offset_reg;
    logic [2:0]       funct3_reg;
    logic             write_reg;
    logic [31:0]      addr_reg;
    logic [31:0]      wdata_reg;
    logic [3:0]       be_reg;
    logic             fault_reg;
    logic [1:0]       cause_reg;
    logic [31:0]      read_data_reg;

    logic        req_illegal, req_misaligned, req_fault;
    logic [1:0]  req_cause;
    logic        handshake, count_hit;
    logic [31:0] st_lane_data, ld_result;
    logic [3:0]  st_byte_en;

    assign req_illegal    = !funct3_legal(i_memWrite, i_funct3);
    assign req_misaligned = addr_misaligned(i_funct3, i_address[1:0]);
    assign req_fault      = req_illegal || req_misaligned;
    assign req_cause      = req_illegal ? CAUSE_ILLEGAL : CAUSE_MISALIGNED;
    assign handshake      = (state_reg == REQ) && i_busReady;
    assign count_hit      = (count_reg == CNT_LAST);

    lsu_lane_align u_lane_align (
        .st_size      (i_funct3[1:0]),
        .st_offset    (i_address[1:0]),
        .st_data      (i_writeData),
        .st_lane_data (st_lane_data),
        .st_byte_en   (st_byte_en),
        .ld_funct3    (funct3_reg),
        .ld_offset    (offset_reg),
        .ld_word      (i_busReadData),
        .ld_result    (ld_result)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (i_memRequest) begin
                    state_next = req_fault ? DONE : REQ;
                end
            end
            REQ: begin
                // The handshake is checked first so it wins over a timeout
                // landing on the same cycle.
                if (handshake) begin
                    state_next = write_reg ? DONE : WAIT_RESP;
                end else if (count_hit) begin
                    state_next = DONE;
                end
            end
            WAIT_RESP: begin
                if (i_busReadValid || count_hit) begin
                    state_next = DONE;
                end
            end
            // The core advances on the DONE edge, so a request still high
            // here belongs to the finished instruction and is ignored.
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_reg     <= IDLE;
            count_reg     <= '0;
            offset_reg    <= 2'b00;
            funct3_reg    <= 3'b000;
            write_reg     <= 1'b0;
            addr_reg      <= 32'h0;
            wdata_reg     <= 32'h0;
            be_reg        <= 4'h0;
            fault_reg     <= 1'b0;
            cause_reg     <= CAUSE_NONE;
            read_data_reg <= 32'h0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (i_memRequest) begin
                        addr_reg   <= {i_address[31:2], 2'b00};
                        offset_reg <= i_address[1:0];
                        funct3_reg <= i_funct3;
                        write_reg  <= i_memWrite;
                        wdata_reg  <= i_memWrite ? st_lane_data : 32'h0;
                        be_reg     <= i_memWrite ? st_byte_en : 4'h0;
                        fault_reg  <= req_fault;
                        cause_reg  <= req_fault ? req_cause : CAUSE_NONE;
                        count_reg  <= '0;
                        if (req_fault) begin
                            read_data_reg <= 32'h0;
                        end
                    end
                end
                REQ: begin
                    if (handshake) begin
                        count_reg <= '0;
                    end else if (count_hit) begin
                        fault_reg     <= 1'b1;
                        cause_reg     <= CAUSE_TIMEOUT;
                        read_data_reg <= 32'h0;
                    end else begin
                        count_reg <= count_reg + 1'b1;
                    end
                end
                WAIT_RESP: begin
                    if (i_busReadValid) begin
                        read_data_reg <= ld_result;
                    end else if (count_hit) begin
                        fault_reg     <= 1'b1;
                        cause_reg     <= CAUSE_TIMEOUT;
                        read_data_reg <= 32'h0;
                    end else begin
                        count_reg <= count_reg + 1'b1;
                    end
                end
                DONE: begin
                    fault_reg <= 1'b0;
                    cause_reg <= CAUSE_NONE;
                end
                default: ;
            endcase
        end
    end

    assign o_stall = ((state_reg == IDLE) && i_memRequest) ||
                     (state_reg == REQ) || (state_reg == WAIT_RESP);
    assign o_busValid      = (state_reg == REQ);
    assign o_busWrite      = write_reg;
    assign o_busAddress    = addr_reg;
    assign o_busWriteData  = wdata_reg;
    assign o_busByteEnable = be_reg;
    assign o_readData      = read_data_reg;
    assign o_fault         = (state_reg == DONE) && fault_reg;
    assign o_faultCause    = (state_reg == DONE) ? cause_reg : 2'b00;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized scoreboard bench for load_store_unit. The driver plays both the
// core and the bus according to a per-transaction plan and pushes the
// expected outcome; an independent monitor checks bus requests and the
// completion cycle against the queued expectations.
module tb_load_store_unit;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_request, mem_write;
    logic [2:0]  funct3;
    logic [31:0] address, write_data;
    logic        stall;
    logic [31:0] read_data;
    logic        fault;
    logic [1:0]  fault_cause;
    logic        bus_valid, bus_ready, bus_write;
    logic [31:0] bus_address, bus_write_data;
    logic [3:0]  bus_byte_enable;
    logic        bus_read_valid;
    logic [31:0] bus_read_data;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT_CYCLES(T)) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_memRequest    (mem_request),
        .i_memWrite      (mem_write),
        .i_funct3        (funct3),
        .i_address       (address),
        .i_writeData     (write_data),
        .o_stall         (stall),
        .o_readData      (read_data),
        .o_fault         (fault),
        .o_faultCause    (fault_cause),
        .o_busValid      (bus_valid),
        .i_busReady      (bus_ready),
        .o_busWrite      (bus_write),
        .o_busAddress    (bus_address),
        .o_busWriteData  (bus_write_data),
        .o_busByteEnable (bus_byte_enable),
        .i_busReadValid  (bus_read_valid),
        .i_busReadData   (bus_read_data)
    );

    typedef struct {
        logic        write;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        int          rd;    // REQ cycles before ready (>= T never ready)
        int          rv;    // WAIT cycles before response (>= T never)
        logic [31:0] word;
        bit          hold;  // keep request high during DONE
    } txn_t;

    typedef struct {
        int          stall;
        int          nvalid;
        logic        fault;
        logic [1:0]  cause;
        logic [31:0] rdata;
        logic        write;
        logic [31:0] baddr;
        logic [3:0]  be;
        logic [31:0] bdata;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_rd = 32'h0;
    logic        rst_q = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: outcome of one transaction from the access rules.
    function automatic exp_t model(input txn_t t, input logic [31:0] prev);
        exp_t        e;
        int          width, off;
        logic        illegal, mis;
        logic [31:0] v;
        width   = 1 << t.f3[1:0];
        off     = int'(t.addr[1:0]);
        illegal = t.write ? (t.f3 > 3'd2) : (t.f3 == 3'd3 || t.f3 > 3'd5);
        mis     = !illegal && ((off % width) != 0);
        e.write = t.write;
        e.baddr = {t.addr[31:2], 2'b00};
        e.be    = 4'h0;
        e.bdata = 32'h0;
        e.fault = 1'b0;
        e.cause = 2'b00;
        e.rdata = prev;
        if (t.write && !illegal) begin
            for (int i = 0; i < 4; i++) begin
                e.bdata[8*i +: 8] = t.wd[8*(i % width) +: 8];
                if (i >= off && i < off + width) e.be[i] = 1'b1;
            end
        end
        if (illegal || mis) begin
            e.fault = 1'b1; e.cause = illegal ? 2'b11 : 2'b01;
            e.stall = 1; e.nvalid = 0; e.rdata = 32'h0;
        end else if (t.rd >= T) begin
            e.fault = 1'b1; e.cause = 2'b10;
            e.stall = 1 + T; e.nvalid = T; e.rdata = 32'h0;
        end else if (t.write) begin
            e.stall = 2 + t.rd; e.nvalid = t.rd + 1;
        end else if (t.rv >= T) begin
            e.fault = 1'b1; e.cause = 2'b10;
            e.stall = 2 + t.rd + T; e.nvalid = t.rd + 1; e.rdata = 32'h0;
        end else begin
            e.stall = 3 + t.rd + t.rv; e.nvalid = t.rd + 1;
            v = t.word >> (8 * off);
            if (width == 1) v = t.f3[2] ? {24'h0, v[7:0]} : {{24{v[7]}}, v[7:0]};
            if (width == 2) v = t.f3[2] ? {16'h0, v[15:0]} : {{16{v[15]}}, v[15:0]};
            e.rdata = v;
        end
        return e;
    endfunction

    function automatic txn_t mk(input logic w, input logic [2:0] f, input logic [31:0] a,
                                input logic [31:0] d, input int rd, input int rv,
                                input logic [31:0] word, input bit hold);
        txn_t t;
        t.write = w; t.f3 = f; t.addr = a; t.wd = d;
        t.rd = rd; t.rv = rv; t.word = word; t.hold = hold;
        return t;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_txn(input txn_t t);
        exp_t e;
        int   nreq, nwait;
        e = model(t, model_rd);
        model_rd = e.rdata;
        exp_q.push_back(e);
        mem_request = 1'b1; mem_write = t.write; funct3 = t.f3;
        address = t.addr; write_data = t.wd;
        bus_ready = 1'b0; bus_read_valid = 1'b0;
        tick();
        if (!(e.fault && e.cause != 2'b10)) begin
            nreq = (t.rd < T) ? t.rd + 1 : T;
            for (int k = 0; k < nreq; k++) begin
                bus_ready = (k == t.rd);
                bus_read_data = $urandom;
                tick();
            end
            bus_ready = 1'b0;
            if (!t.write && t.rd < T) begin
                nwait = (t.rv < T) ? t.rv + 1 : T;
                for (int j = 0; j < nwait; j++) begin
                    bus_read_valid = (j == t.rv);
                    bus_read_data = (j == t.rv) ? t.word : $urandom;
                    tick();
                end
            end
            bus_read_valid = 1'b0;
        end
        mem_request = t.hold;   // DONE cycle
        tick();
        mem_request = 1'b0;
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) begin
            mem_request = 1'b0;
            bus_read_valid = $urandom_range(0, 1);
            bus_read_data = $urandom;
            tick();
        end
        bus_read_valid = 1'b0;
    endtask

    // Monitor / scoreboard
    int stall_cnt = 0;
    int valid_cnt = 0;
    bit stall_prev = 1'b0;
    bit hung = 1'b0;
    logic [31:0] hold_rd = 32'h0;

    always @(posedge clk) rst_q <= rst_n;

    always @(negedge clk) begin
        exp_t e;
        bit   done;
        if (!rst_q) begin
            chk("reset_ctrl", {24'h0, stall, bus_valid, bus_write, fault, fault_cause, 2'b00},
                32'h0);
            chk("reset_be", {28'h0, bus_byte_enable}, 32'h0);
            chk("reset_addr", bus_address, 32'h0);
            chk("reset_wdata", bus_write_data, 32'h0);
            chk("reset_rdata", read_data, 32'h0);
            exp_q.delete();
            hold_rd = 32'h0; stall_cnt = 0; valid_cnt = 0; stall_prev = 1'b0;
        end else begin
            done = stall_prev && !stall;
            if (bus_valid) begin
                valid_cnt++;
                if (exp_q.size() == 0) begin
                    chk("bus_unexpected", {31'h0, bus_valid}, 32'h0);
                end else begin
                    e = exp_q[0];
                    chk("bus_addr", bus_address, e.baddr);
                    chk("bus_write", {31'h0, bus_write}, {31'h0, e.write});
                    if (e.write) begin
                        chk("bus_be", {28'h0, bus_byte_enable}, {28'h0, e.be});
                        chk("bus_data", bus_write_data, e.bdata);
                    end
                end
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("done_unexpected", 32'h1, 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    chk("stall_cycles", stall_cnt, e.stall);
                    chk("valid_cycles", valid_cnt, e.nvalid);
                    chk("fault", {31'h0, fault}, {31'h0, e.fault});
                    chk("fault_cause", {30'h0, fault_cause}, {30'h0, e.cause});
                    chk("read_data", read_data, e.rdata);
                    hold_rd = e.rdata;
                end
                stall_cnt = 0;
                valid_cnt = 0;
            end else begin
                chk("fault_outside_done", {30'h0, fault, fault_cause[1]|fault_cause[0]}, 32'h0);
                chk("read_data_hold", read_data, hold_rd);
                if (exp_q.size() == 0) chk("idle_stall", {31'h0, stall}, 32'h0);
            end
            if (stall) stall_cnt++;
            if (stall_cnt > 64 && !hung) begin
                hung = 1'b1;
                chk("stall_bound", stall_cnt, 64);
            end
            stall_prev = stall;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        txn_t t;
        logic [31:0] r;
        rst_n = 1'b0; mem_request = 1'b0; mem_write = 1'b0; funct3 = 3'b0;
        address = 32'h0; write_data = 32'h0; bus_ready = 1'b0;
        bus_read_valid = 1'b0; bus_read_data = 32'h0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // Directed cases
        run_txn(mk(1'b0, 3'b010, 32'h100, 32'h0, 0, 1, 32'hDEADBEEF, 1'b0)); gap(1);
        run_txn(mk(1'b0, 3'b000, 32'h103, 32'h0, 0, 0, 32'h80FF1234, 1'b0)); gap(1);
        run_txn(mk(1'b0, 3'b100, 32'h103, 32'h0, 1, 2, 32'h80FF1234, 1'b1)); gap(0);
        run_txn(mk(1'b0, 3'b101, 32'h102, 32'h0, 0, 0, 32'h80FF1234, 1'b0)); gap(1);
        run_txn(mk(1'b1, 3'b001, 32'h102, 32'h0000ABCD, 3, 0, 32'h0, 1'b0)); gap(1);
        run_txn(mk(1'b0, 3'b010, 32'h101, 32'h0, 0, 0, 32'h0, 1'b1)); gap(1);
        run_txn(mk(1'b0, 3'b011, 32'h100, 32'h0, 0, 0, 32'h0, 1'b0)); gap(1);
        run_txn(mk(1'b1, 3'b010, 32'h200, 32'h12345678, 9, 0, 32'h0, 1'b0)); gap(1);
        run_txn(mk(1'b1, 3'b000, 32'h203, 32'h000000A5, 3, 0, 32'h0, 1'b1)); gap(1);
        run_txn(mk(1'b0, 3'b001, 32'h202, 32'h0, 0, 3, 32'hC0DE8001, 1'b0)); gap(1);
        run_txn(mk(1'b0, 3'b010, 32'h204, 32'h0, 2, 7, 32'h55AA55AA, 1'b0)); gap(1);
        run_txn(mk(1'b1, 3'b111, 32'h204, 32'h1, 0, 0, 32'h0, 1'b0)); gap(1);

        // Randomized traffic
        for (int n = 0; n < 150; n++) begin
            t.write = $urandom_range(0, 1);
            if ($urandom_range(0, 3) == 0) t.f3 = 3'($urandom_range(0, 7));
            else if (t.write) t.f3 = 3'($urandom_range(0, 2));
            else begin
                r = $urandom_range(0, 4);
                t.f3 = (r > 2) ? 3'(r + 1) : 3'(r);
            end
            r = $urandom;
            t.addr = {r[31:2], 2'b00} | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) t.addr[1:0] = 2'b00;
            t.wd   = $urandom;
            t.word = $urandom;
            t.rd   = ($urandom_range(0, 7) == 0) ? $urandom_range(T, T + 2) : $urandom_range(0, T - 1);
            t.rv   = ($urandom_range(0, 7) == 0) ? $urandom_range(T, T + 2) : $urandom_range(0, T - 1);
            t.hold = $urandom_range(0, 1);
            run_txn(t);
            gap($urandom_range(0, 2));
        end

        // Give o_readData a known nonzero value, then reset in WAIT_RESP.
        run_txn(mk(1'b0, 3'b010, 32'h300, 32'h0, 0, 0, 32'hFEEDFACE, 1'b0)); gap(1);
        t = mk(1'b0, 3'b010, 32'h304, 32'h0, 0, 9, 32'h0, 1'b0);
        void'(model(t, model_rd));
        exp_q.push_back(model(t, model_rd));
        mem_request = 1'b1; mem_write = 1'b0; funct3 = 3'b010; address = 32'h304;
        tick();                       // IDLE
        bus_ready = 1'b1; tick();     // REQ with handshake
        bus_ready = 1'b0; tick();     // WAIT_RESP
        rst_n = 1'b0; mem_request = 1'b0;
        tick();                       // reset edge lands in WAIT_RESP
        rst_n = 1'b1;
        model_rd = 32'h0;
        bus_read_valid = 1'b1; bus_read_data = 32'h12345678;
        repeat (3) tick();            // stale responses must be ignored
        bus_read_valid = 1'b0;
        gap(1);
        run_txn(mk(1'b1, 3'b010, 32'h400, 32'hCAFEF00D, 0, 0, 32'h0, 1'b0)); gap(2);

        repeat (3) tick();
        chk("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Data-memory access stage directly downstream of the ALU in the single-cycle core.
- Takes the ALU result as the effective address and rs2 as store data.
- Runs a multi-cycle valid/ready transaction on the data bus. Stalls the core (PC and register writeback held) until the access completes.
- Returns aligned, sign/zero-extended load data. Flags misaligned, illegal-width and timed-out accesses.

Parameters:
- TIMEOUT_CYCLES, 255, max cycles waiting for i_busReady or i_busReadValid before a timeout fault; must be >= 1.

Ports:
- i_clk  input  1  core clock, all state on rising edge.
- i_rst_n  input  1  synchronous active-low reset.
- i_memRequest  input  1  current instruction is a load or store.
- i_memWrite  input  1  1 = store, 0 = load.
- i_funct3  input  3  access width/sign (pa_riscv load/store encoding).
- i_address  input  32  effective address from ALU o_result.
- i_writeData  input  32  store data (rs2).
- o_stall  output  1  hold PC/writeback this cycle.
- o_readData  output  32  extended load result, valid in DONE.
- o_fault  output  1  one-cycle pulse in DONE when the access faulted.
- o_faultCause  output  2  01 misaligned, 10 timeout, 11 illegal funct3; 00 when no fault.
- o_busValid  output  1  request valid.
- i_busReady  input  1  bus accepts request.
- o_busWrite  output  1  request is a write.
- o_busAddress  output  32  word-aligned address ({addr[31:2],2'b00}).
- o_busWriteData  output  32  lane-replicated store data.
- o_busByteEnable  output  4  byte lanes written.
- i_busReadValid  input  1  read response valid.
- i_busReadData  input  32  read response word.

Behaviour:
- Reset is synchronous, active-low, and overrides everything, including mid-transaction.
- Reset values: state IDLE; o_busValid, o_busWrite, o_fault = 0; o_busAddress, o_busWriteData, o_readData = 0; o_busByteEnable = 0; o_faultCause = 00; timeout counter = 0; o_stall = 0.
- Stale i_busReadValid after reset is ignored.
- FSM states: IDLE, REQ, WAIT_RESP, DONE.
- o_stall = (IDLE && i_memRequest) || REQ || WAIT_RESP. It is 0 in DONE.
- IDLE:
  - On i_memRequest, register address, funct3, write flag, lane data and byte enables.
  - Legal and aligned -> REQ.
  - Misaligned (H with addr[0]=1; W with addr[1:0]!=0) or illegal funct3 (load 011/110/111; store other than 000/001/010) -> DONE with fault. No bus access.
- REQ:
  - o_busValid = 1. Address, data, enables and write are stable until handshake.
  - Handshake = o_busValid && i_busReady.
  - On handshake: store -> DONE; load -> WAIT_RESP.
  - o_busValid drops the cycle after the handshake.
- WAIT_RESP: on i_busReadValid, capture the extended data -> DONE.
- Timeout:
  - Counter clears on entry to REQ/WAIT_RESP and increments each cycle spent there.
  - On reaching TIMEOUT_CYCLES without the awaited event -> DONE, cause 10, o_busValid dropped.
  - A handshake or response on the same cycle the count is reached wins over the timeout.
- DONE:
  - Lasts one cycle, then IDLE unconditionally.
  - The core advances on this edge; a still-high i_memRequest in DONE is not restarted.
  - o_fault/o_faultCause valid only in DONE; o_readData = 0 on fault.
- Store lanes:
  - SB: data = {4{wd[7:0]}}, BE = 0001 << addr[1:0].
  - SH: data = {2{wd[15:0]}}, BE = addr[1] ? 1100 : 0011.
  - SW: data = wd, BE = 1111.
- Load extract:
  - Shift = 8*addr[1:0].
  - LB/LH sign-extend bit 7/15; LBU/LHU zero-extend; LW passes the word.
- o_readData holds its last value outside DONE.
- Latency: store with immediate ready = 2 cycles stalled. Load = 2 + response delay.

Decomposition:
- Add to pa_riscv:
  - load/store funct3 enum (LB, LH, LW, LBU, LHU, SB, SH, SW);
  - FSM state enum;
  - fault-cause enum.
- One natural sub-module, lsu_lane_align: purely combinational store-lane replication/byte-enable generation and load extract/extension. This keeps the FSM module focused on handshake and timeout.

Test Plan:
- LW addr 0x100, ready on first REQ cycle, i_busReadValid two cycles later with 0xDEADBEEF -> o_busAddress 0x100, BE 0000 irrelevant/write 0, o_stall high 4 cycles, DONE o_readData 0xDEADBEEF, o_fault 0.
- LB addr 0x103, response 0x80FF1234 -> 0xFFFFFF80. LBU same -> 0x00000080. LHU addr 0x102 -> 0x000080FF.
- SH addr 0x102 wd 0x0000ABCD, i_busReady low 3 cycles -> o_busValid/address 0x100/BE 1100/data 0xABCDABCD stable all 4 REQ cycles, DONE next cycle, no WAIT_RESP.
- LW addr 0x101 -> no o_busValid ever. DONE one cycle after request with o_fault 1, cause 01, o_readData 0. funct3 011 -> cause 11.
- TIMEOUT_CYCLES=4, i_busReady never asserted -> exactly 4 REQ cycles, then DONE cause 10, o_busValid 0. Ready arriving on the 4th cycle -> normal completion instead.
- Reset asserted in WAIT_RESP -> next cycle IDLE, all outputs at reset values. i_busReadValid arriving after reset -> no DONE, o_readData stays 0.
